// File: rtl/mul4_pkg.sv
// ---------------------------------------------------------------------------
// mul4_pkg
// Shared definitions for the 2x2 multiplier fitness scorer.
//   LANES          : test cases carried side by side in one batch
//   BITS_PER_BATCH : output bits compared per batch (4 product bits x LANES)
//   SCORE_W        : width of the run accumulator / score output
//   COUNT_W        : width of a single-batch hit count (0..64)
//   state_t        : scorer FSM states
//   match_vector() : golden 2x2 product per lane, compared against a candidate
// ---------------------------------------------------------------------------
package mul4_pkg;

   localparam int LANES          = 16;
   localparam int BITS_PER_BATCH = 64;
   localparam int SCORE_W        = 16;
   localparam int COUNT_W        = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      DRAIN  = 2'd2,
      REPORT = 2'd3
   } state_t;

   // Returns a 1 in every bit position where the candidate output agrees with
   // the golden product. Bit order is {y3, y2, y1, y0}, each LANES wide.
   // p2 excludes the 3*3 lane, whose product 9 has bit 2 clear; only that
   // lane sets p3.
   function automatic logic [BITS_PER_BATCH-1:0] match_vector(
      input logic [LANES-1:0] a1,
      input logic [LANES-1:0] a0,
      input logic [LANES-1:0] b1,
      input logic [LANES-1:0] b0,
      input logic [LANES-1:0] y3,
      input logic [LANES-1:0] y2,
      input logic [LANES-1:0] y1,
      input logic [LANES-1:0] y0
   );
      logic [LANES-1:0] p0;
      logic [LANES-1:0] p1;
      logic [LANES-1:0] p2;
      logic [LANES-1:0] p3;
      p0 = a0 & b0;
      p1 = (a1 & b0) ^ (a0 & b1);
      p2 = a1 & b1 & ~(a0 & b0);
      p3 = a1 & a0 & b1 & b0;
      return ~({y3, y2, y1, y0} ^ {p3, p2, p1, p0});
   endfunction

endpackage

// File: rtl/mul4_popcount64.sv
// ---------------------------------------------------------------------------
// mul4_popcount64
// Purely combinational population count of a 64-bit match vector.
//   bits  : input vector (one bit per compared product bit)
//   count : number of ones in bits, 0..64
// ---------------------------------------------------------------------------
module mul4_popcount64
   import mul4_pkg::*;
(
   input  logic [BITS_PER_BATCH-1:0] bits,
   output logic [COUNT_W-1:0]        count
);

   // Sum nibble counts first so synthesis sees a shallow adder tree rather
   // than one long ripple chain of 64 single-bit additions.
   logic [2:0] nib_count [BITS_PER_BATCH/4];

   always_comb begin
      for (int n = 0; n < BITS_PER_BATCH/4; n++) begin
         nib_count[n] = 3'(bits[4*n])   + 3'(bits[4*n+1])
                      + 3'(bits[4*n+2]) + 3'(bits[4*n+3]);
      end
   end

   always_comb begin
      count = '0;
      for (int n = 0; n < BITS_PER_BATCH/4; n++) begin
         count = count + COUNT_W'(nib_count[n]);
      end
   end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// ---------------------------------------------------------------------------
// mul4_fitness_scorer
// Scores an evolved 2x2 multiplier: each batch carries 16 bit-sliced test
// cases plus the candidate's 4 output bits per case; the scorer counts how
// many of the 64 output bits match the golden product and sums that over a
// run of num_batches batches.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   start, num_batches  : begin a run of num_batches batches (IDLE only)
//   in_valid, in_ready  : batch handshake (accepted on in_valid && in_ready)
//   a1, a0, b1, b0      : bit-sliced operands, lane i = {a1[i],a0[i]} etc.
//   y3, y2, y1, y0      : bit-sliced candidate product
//   score, perfect      : run result, valid while out_valid
//   out_valid, out_ready: result handshake
//
// Batch counts above MAX_BATCHES are clamped to MAX_BATCHES.
// ---------------------------------------------------------------------------
module mul4_fitness_scorer
   import mul4_pkg::*;
#(
   parameter int MAX_BATCHES = 255
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [7:0]         num_batches,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES-1:0]   a1,
   input  logic [LANES-1:0]   a0,
   input  logic [LANES-1:0]   b1,
   input  logic [LANES-1:0]   b0,
   input  logic [LANES-1:0]   y3,
   input  logic [LANES-1:0]   y2,
   input  logic [LANES-1:0]   y1,
   input  logic [LANES-1:0]   y0,
   output logic [SCORE_W-1:0] score,
   output logic               perfect,
   output logic               out_valid,
   input  logic               out_ready
);

   state_t                    state;
   state_t                    state_next;
   logic [7:0]                remaining;
   logic [7:0]                batches;
   logic [7:0]                start_count;
   logic                      accept;
   logic                      run_start;
   logic                      s1_valid;
   logic [BITS_PER_BATCH-1:0] s1_match;
   logic [COUNT_W-1:0]        s1_hits;
   logic [SCORE_W-1:0]        acc;
   logic [SCORE_W-1:0]        perfect_target;

   // Clamp the requested run length to the configured maximum.
   assign start_count = (num_batches > 8'(MAX_BATCHES)) ? 8'(MAX_BATCHES)
                                                        : num_batches;

   assign run_start = (state == IDLE) && start;
   assign in_ready  = (state == ACCUM) && (remaining != 8'd0);
   assign accept    = in_valid && in_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. ACCUM is left on the edge that accepts the final
   // batch; DRAIN gives stage 2 one edge to fold that batch into acc before
   // the result is presented.
   always_comb begin
      state_next = state;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (start_count == 8'd0) ? REPORT : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && (remaining == 8'd1)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = REPORT;
         end
         REPORT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Run bookkeeping: batches remembers the run length for the perfect test,
   // remaining counts down one per accepted batch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         remaining <= 8'd0;
         batches   <= 8'd0;
      end else if (run_start) begin
         remaining <= start_count;
         batches   <= start_count;
      end else if (accept) begin
         remaining <= remaining - 8'd1;
      end
   end

   // Stage 1: capture the match vector of the accepted batch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_match <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_match <= match_vector(a1, a0, b1, b0, y3, y2, y1, y0);
         end
      end
   end

   mul4_popcount64 u_popcount (
      .bits  (s1_match),
      .count (s1_hits)
   );

   // Stage 2: fold the stage-1 hit count into the run accumulator. A new
   // run cannot start while stage 1 is occupied, so the clear never races
   // an addition.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (run_start) begin
         acc <= '0;
      end else if (s1_valid) begin
         acc <= acc + SCORE_W'(s1_hits);
      end
   end

   // Result outputs are forced to zero outside REPORT so a partially
   // accumulated score is never visible.
   assign perfect_target = {2'b00, batches, 6'b000000};
   assign score          = out_valid ? acc : '0;
   assign perfect        = out_valid && (batches != 8'd0) && (acc == perfect_target);

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// ---------------------------------------------------------------------------
// tb_mul4_fitness_scorer
// Self-checking bench for mul4_fitness_scorer. The reference model multiplies
// the lane operands arithmetically and compares product bits one by one.
// ---------------------------------------------------------------------------
module tb_mul4_fitness_scorer;

   typedef struct {
      logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
   } batch_t;

   typedef struct {
      batch_t b;
      int     exp_score;
      int     exp_perfect;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  num_batches;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
   logic [15:0] score;
   logic        perfect;
   logic        out_valid;
   logic        out_ready;

   batch_t bq [16];
   vec_t   vt [6];
   int     num_checks = 0;
   int     num_fail   = 0;

   always #5 clk = ~clk;

   mul4_fitness_scorer #(.MAX_BATCHES(255)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .num_batches (num_batches),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a1          (a1),
      .a0          (a0),
      .b1          (b1),
      .b0          (b0),
      .y3          (y3),
      .y2          (y2),
      .y1          (y1),
      .y0          (y0),
      .score       (score),
      .perfect     (perfect),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   // Candidate outputs that equal the true product A*B on every lane.
   function automatic batch_t goldenBatch(input logic [15:0] ia1, ia0, ib1, ib0);
      batch_t r;
      int     pa, pb, pp;
      r.a1 = ia1; r.a0 = ia0; r.b1 = ib1; r.b0 = ib0;
      r.y3 = '0;  r.y2 = '0;  r.y1 = '0;  r.y0 = '0;
      for (int i = 0; i < 16; i++) begin
         pa = 2 * int'(ia1[i]) + int'(ia0[i]);
         pb = 2 * int'(ib1[i]) + int'(ib0[i]);
         pp = pa * pb;
         r.y0[i] = pp[0];
         r.y1[i] = pp[1];
         r.y2[i] = pp[2];
         r.y3[i] = pp[3];
      end
      return r;
   endfunction

   // Number of candidate output bits that agree with the true product.
   function automatic int modelHits(input batch_t t);
      int hits = 0;
      int pa, pb, pp, yy;
      for (int i = 0; i < 16; i++) begin
         pa = 2 * int'(t.a1[i]) + int'(t.a0[i]);
         pb = 2 * int'(t.b1[i]) + int'(t.b0[i]);
         pp = pa * pb;
         yy = 8 * int'(t.y3[i]) + 4 * int'(t.y2[i]) + 2 * int'(t.y1[i]) + int'(t.y0[i]);
         for (int k = 0; k < 4; k++) begin
            if (pp[k] == yy[k]) hits++;
         end
      end
      return hits;
   endfunction

   function automatic int modelScore(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += modelHits(bq[i % 16]);
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      num_checks++;
      if (actual !== expected) begin
         num_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic driveBatch(input batch_t t);
      a1 = t.a1; a0 = t.a0; b1 = t.b1; b0 = t.b0;
      y3 = t.y3; y2 = t.y2; y1 = t.y1; y0 = t.y0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // One full run: start, feed n batches from bq (wrapping), wait for the
   // result, optionally stall the consumer for hold cycles while pulsing
   // start, then complete the handshake.
   task automatic applyStimulus(input int n, input bit always_valid, input int hold,
                                input int exp_score, input int exp_perfect,
                                output int ready_cycles, output int lat);
      int  idx = 0;
      int  cyc = 0;
      bit  took;
      ready_cycles = 0;
      start = 1'b1;
      num_batches = 8'(n);
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      while (idx < n && cyc < 4000) begin
         driveBatch(bq[idx % 16]);
         in_valid = always_valid ? 1'b1 : ($urandom_range(0, 9) < 7);
         if (in_ready) ready_cycles++;
         took = in_valid && in_ready;
         tick();
         cyc++;
         if (took) idx++;
      end
      in_valid = 1'b0;
      checkOutput("batches accepted", idx, n);
      lat = 1;
      while (!out_valid && lat < 50) begin
         if (in_ready) ready_cycles++;
         tick();
         lat++;
      end
      checkOutput("out_valid raised", int'(out_valid), 1);
      checkOutput("score", int'(score), exp_score);
      checkOutput("perfect", int'(perfect), exp_perfect);
      for (int h = 0; h < hold; h++) begin
         start = 1'b1;
         num_batches = 8'd0;
         tick();
         checkOutput("held out_valid", int'(out_valid), 1);
         checkOutput("held score", int'(score), exp_score);
         checkOutput("held perfect", int'(perfect), exp_perfect);
      end
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("idle after handshake", int'(out_valid), 0);
   endtask

   initial begin
      batch_t base;
      int     rc, lat, n, es, ep;

      rst_n = 1'b0; start = 1'b0; num_batches = '0; in_valid = 1'b0; out_ready = 1'b0;
      a1 = '0; a0 = '0; b1 = '0; b0 = '0; y3 = '0; y2 = '0; y1 = '0; y0 = '0;

      doReset();
      checkOutput("reset in_ready", int'(in_ready), 0);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset score", int'(score), 0);
      checkOutput("reset perfect", int'(perfect), 0);

      // Lane i carries A = i[1:0], B = i[3:2]: every operand pair once.
      // Its true product has 14 set bits out of 64.
      base = '{a1: 16'hCCCC, a0: 16'hAAAA, b1: 16'hFF00, b0: 16'hF0F0,
               y3: 16'h8000, y2: 16'h4C00, y1: 16'h6AC0, y0: 16'hA0A0};
      vt[0] = '{b: base, exp_score: 64, exp_perfect: 1};
      vt[1] = '{b: base, exp_score: 50, exp_perfect: 0};
      vt[1].b.y3 = '0; vt[1].b.y2 = '0; vt[1].b.y1 = '0; vt[1].b.y0 = '0;
      vt[2] = '{b: base, exp_score: 14, exp_perfect: 0};
      vt[2].b.y3 = '1; vt[2].b.y2 = '1; vt[2].b.y1 = '1; vt[2].b.y0 = '1;
      vt[3] = '{b: '{a1: '0, a0: '0, b1: '0, b0: '0, y3: '0, y2: '0, y1: '0, y0: '0},
                exp_score: 64, exp_perfect: 1};
      // 3*3 = 9 on every lane.
      vt[4] = '{b: '{a1: '1, a0: '1, b1: '1, b0: '1, y3: '1, y2: '0, y1: '0, y0: '1},
                exp_score: 64, exp_perfect: 1};
      vt[5] = '{b: '{a1: '1, a0: '1, b1: '1, b0: '1, y3: '0, y2: '0, y1: '0, y0: '0},
                exp_score: 32, exp_perfect: 0};

      for (int i = 0; i < 6; i++) begin
         bq[0] = vt[i].b;
         applyStimulus(1, 1'b1, 0, vt[i].exp_score, vt[i].exp_perfect, rc, lat);
      end

      // Three correct batches back to back.
      for (int i = 0; i < 3; i++)
         bq[i] = goldenBatch(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      applyStimulus(3, 1'b1, 0, 192, 1, rc, lat);
      checkOutput("3-batch in_ready cycles", rc, 3);
      checkOutput("3-batch result latency", lat, 2);

      // Empty run.
      applyStimulus(0, 1'b1, 0, 0, 0, rc, lat);
      checkOutput("empty in_ready cycles", rc, 0);
      checkOutput("empty result latency", lat, 1);

      // Consumer stall with start pulses in REPORT.
      bq[0] = goldenBatch(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
      applyStimulus(1, 1'b1, 5, 64, 1, rc, lat);

      // Reset one cycle after the first of three batches is accepted.
      for (int i = 0; i < 3; i++)
         bq[i] = goldenBatch(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      start = 1'b1; num_batches = 8'd3;
      tick();
      start = 1'b0;
      driveBatch(bq[0]);
      in_valid = 1'b1;
      checkOutput("abort first in_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("abort in_ready", int'(in_ready), 0);
      checkOutput("abort out_valid", int'(out_valid), 0);
      checkOutput("abort score", int'(score), 0);
      checkOutput("abort perfect", int'(perfect), 0);
      tick(); tick(); tick();
      checkOutput("abort stays idle", int'(out_valid) + int'(in_ready), 0);
      bq[0] = goldenBatch(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      applyStimulus(1, 1'b1, 0, 64, 1, rc, lat);

      // Longest run: 255 correct batches reach the full 16320.
      for (int i = 0; i < 16; i++)
         bq[i] = goldenBatch(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      applyStimulus(255, 1'b1, 0, 255 * 64, 1, rc, lat);
      checkOutput("max run in_ready cycles", rc, 255);

      // Randomised runs with stalls and corrupted candidates.
      for (int r = 0; r < 25; r++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            bq[i] = goldenBatch(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 2) != 0) begin
               bq[i].y0 ^= 16'($urandom) & 16'($urandom);
               bq[i].y1 ^= 16'($urandom) & 16'($urandom);
               bq[i].y2 ^= 16'($urandom) & 16'($urandom) & 16'($urandom);
               bq[i].y3 ^= 16'($urandom) & 16'($urandom) & 16'($urandom);
            end
         end
         es = modelScore(n);
         ep = (es == n * 64) ? 1 : 0;
         applyStimulus(n, 1'b0, $urandom_range(0, 2), es, ep, rc, lat);
         checkOutput("random result latency", lat, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
